// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 key-schedule types, round count, state
//               encoding and the Rcon round-constant lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_EMIT   = 2'd2
  } state_e;

  // Round constant for round k (1..10) in the top byte; zero elsewhere.
  function automatic word_t rcon(input logic [3:0] k);
    word_t r;
    r = '0;
    case (k)
      4'd1:    r = 32'h01000000;
      4'd2:    r = 32'h02000000;
      4'd3:    r = 32'h04000000;
      4'd4:    r = 32'h08000000;
      4'd5:    r = 32'h10000000;
      4'd6:    r = 32'h20000000;
      4'd7:    r = 32'h40000000;
      4'd8:    r = 32'h80000000;
      4'd9:    r = 32'h1b000000;
      4'd10:   r = 32'h36000000;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_schedule_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : key_schedule_ctrl_if
// Description : Key-load and round-key stream handshakes of the AES-128 key
//               schedule sequencer. master = environment, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_schedule_ctrl_if;
  import aes_pkg::*;

  key_t       key_in;
  logic       key_valid;
  logic       key_ready;
  logic       dec;
  key_t       rk_data;
  logic [3:0] rk_index;
  logic       rk_valid;
  logic       rk_ready;
  logic       busy;
  logic       done;

  modport master (
    output key_in, key_valid, dec, rk_ready,
    input  key_ready, rk_data, rk_index, rk_valid, busy, done
  );

  modport slave (
    input  key_in, key_valid, dec, rk_ready,
    output key_ready, rk_data, rk_index, rk_valid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/sub_word.sv
`default_nettype none
// ============================================================================
// Module      : sub_word
// Description : AES SubWord - four parallel S-box lookups on a 32-bit word.
//               Purely combinational; shared with the round datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_word
  import aes_pkg::*;
(
  input  word_t word_in,
  output word_t word_out
);

  // S-box packed with entry 0x00 in the most significant byte, so entry b
  // sits at bit offset 8*(255-b) = {~b, 3'b000}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign word_out[8*g +: 8] = SBOX[{~word_in[8*g +: 8], 3'b000} +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_schedule_ctrl
// Description : AES-128 key-expansion sequencer. Accepts a cipher key and
//               streams round keys 0..10 (forward) or 10..0 (reverse).
//               Optional feature macro: KEY_SCHED_REVERSE_EN enables the
//               11-entry round-key buffer, the EXPAND state and dec.
// Revision    : 1.0 - initial release
// ============================================================================
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  key_schedule_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_EMIT   = ST_EMIT;
`ifdef KEY_SCHED_REVERSE_EN
  localparam logic [1:0] S_EXPAND = ST_EXPAND;
`endif
  localparam logic [3:0] LAST_J   = 4'(NR);

  logic [1:0] state;
  logic [3:0] j;
  key_t       key_reg;
  logic       done_r;
  logic       rev;
  logic       last_step;
  word_t      w3_rot;
  word_t      w3_sub;
  word_t      t;
  word_t      w0n, w1n, w2n, w3n;
  key_t       next_key;

  // Next round key from the current one: RotWord, SubWord, Rcon(j+1).
  assign w3_rot = {key_reg[23:0], key_reg[31:24]};

  sub_word u_sub_word (
    .word_in  (w3_rot),
    .word_out (w3_sub)
  );

  assign t = w3_sub ^ rcon(j + 4'd1);

  // Chained word XORs of the key expansion step.
  always_comb begin
    w0n      = key_reg[127:96] ^ t;
    w1n      = key_reg[95:64]  ^ w0n;
    w2n      = key_reg[63:32]  ^ w1n;
    w3n      = key_reg[31:0]   ^ w2n;
    next_key = {w0n, w1n, w2n, w3n};
  end

  assign last_step = rev ? (j == 4'd0) : (j == LAST_J);

`ifdef KEY_SCHED_REVERSE_EN
  key_t buffer [0:NR];

  // Direction latched with the key; only the reverse build honours dec.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rev <= 1'b0;
    end else if (state == S_IDLE && bus.key_valid) begin
      rev <= bus.dec;
    end
  end

  // Round-key buffer: key at slot 0, each derived round key at slot j+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) buffer[i] <= '0;
    end else if (state == S_IDLE && bus.key_valid) begin
      buffer[0] <= bus.key_in;
    end else if (state == S_EXPAND ||
                 (state == S_EMIT && !rev && bus.rk_ready && j != LAST_J)) begin
      buffer[j + 4'd1] <= next_key;
    end
  end

  assign bus.rk_data = (state != S_EMIT) ? '0 : (rev ? buffer[j] : key_reg);
`else
  logic unused_dec;
  assign unused_dec  = bus.dec;
  assign rev         = 1'b0;
  assign bus.rk_data = (state == S_EMIT) ? key_reg : '0;
`endif

  // Sequencer FSM: round counter, key register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      j       <= 4'd0;
      key_reg <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.key_valid) begin
            key_reg <= bus.key_in;
            j       <= 4'd0;
`ifdef KEY_SCHED_REVERSE_EN
            state   <= bus.dec ? S_EXPAND : S_EMIT;
`else
            state   <= S_EMIT;
`endif
          end
        end
`ifdef KEY_SCHED_REVERSE_EN
        S_EXPAND: begin
          key_reg <= next_key;
          j       <= j + 4'd1;
          if (j == LAST_J - 4'd1) state <= S_EMIT;
        end
`endif
        S_EMIT: begin
          if (bus.rk_ready) begin
            if (last_step) begin
              state  <= S_IDLE;
              done_r <= 1'b1;
            end else if (rev) begin
              j <= j - 4'd1;
            end else begin
              key_reg <= next_key;
              j       <= j + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.key_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.rk_valid  = (state == S_EMIT);
  assign bus.rk_index  = (state == S_EMIT) ? j : 4'd0;
  assign bus.done      = done_r;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_schedule_ctrl
// Description : Self-checking bench for key_schedule_ctrl. Reference keys come
//               from a FIPS-197 style expansion using an S-box derived from
//               GF(2^8) inversion plus the affine map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_schedule_ctrl;

  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  key_schedule_ctrl_if ks_if ();

  key_schedule_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ks_if)
  );

  // ---------------- reference arithmetic ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      if (a != 0) begin
        inv = 8'h01;
        repeat (254) inv = gmul(inv, 8'(a));
      end
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                rotl8(inv, 4) ^ 8'h63;
    end
  end

  // All eleven round keys, round r at bits [r*128 +: 128].
  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [0:43];
    logic [31:0]   tmp;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      res[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic          m_idle = 1'b1;
  int            m_wait = 0;
  logic          m_done = 1'b0;
  logic [127:0]  q_data [$];
  int            q_idx  [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_wait = 0; m_done = 1'b0;
      q_data.delete(); q_idx.delete();
    end else begin
      m_done = 1'b0;
      if (m_idle) begin
        if (ks_if.key_valid) begin
          logic [1407:0] all;
          logic          rv;
          all = expand(ks_if.key_in);
`ifdef KEY_SCHED_REVERSE_EN
          rv = ks_if.dec;
`else
          rv = 1'b0;
`endif
          for (int r = 0; r < 11; r++) begin
            int idx;
            idx = rv ? 10 - r : r;
            q_data.push_back(all[idx*128 +: 128]);
            q_idx.push_back(idx);
          end
          m_wait = rv ? 10 : 0;
          m_idle = 1'b0;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (ks_if.rk_ready) begin
        void'(q_data.pop_front());
        void'(q_idx.pop_front());
        if (q_data.size() == 0) begin
          m_idle = 1'b1;
          m_done = 1'b1;
        end
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    logic exp_valid;
    exp_valid = !m_idle && m_wait == 0;
    check("key_ready", 128'(ks_if.key_ready), 128'(m_idle));
    check("busy",      128'(ks_if.busy),      128'(!m_idle));
    check("rk_valid",  128'(ks_if.rk_valid),  128'(exp_valid));
    check("done",      128'(ks_if.done),      128'(m_done));
    if (exp_valid && q_data.size() > 0) begin
      check("rk_data",  ks_if.rk_data,        q_data[0]);
      check("rk_index", 128'(ks_if.rk_index), 128'(q_idx[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int budget = 60;
    while (!ks_if.key_ready && budget > 0) begin
      step();
      budget--;
    end
    if (!ks_if.key_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, key_ready stayed %b required 1", name, ks_if.key_ready);
    end
  endtask

  task automatic start_key(input logic [127:0] k, input logic d);
    ks_if.key_in    = k;
    ks_if.dec       = d;
    ks_if.key_valid = 1'b1;
    ks_if.rk_ready  = 1'b1;
    step();
    ks_if.key_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1407:0] all;
    logic [127:0]  kb;
    int            guard;
    ks_if.key_in = '0; ks_if.key_valid = 1'b0; ks_if.dec = 1'b0; ks_if.rk_ready = 1'b0;
    repeat (3) step();
    check("rst_key_ready", 128'(ks_if.key_ready), 128'd1);
    check("rst_rk_valid",  128'(ks_if.rk_valid),  128'd0);
    check("rst_busy",      128'(ks_if.busy),      128'd0);
    check("rst_rk_data",   ks_if.rk_data,         128'd0);
    check("rst_done",      128'(ks_if.done),      128'd0);
    rst_n = 1'b1;
    step();

    all = expand(K0);
    check("model_rk1",  all[128 +: 128],  R1);
    check("model_rk10", all[1280 +: 128], R10);

    // Forward stream of the reference key, rk_ready held high.
    start_key(K0, 1'b0);
    check("fwd_idx0",  128'(ks_if.rk_index), 128'd0);
    check("fwd_data0", ks_if.rk_data, K0);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1)  check("fwd_data1", ks_if.rk_data, R1);
      if (i == 10) begin
        check("fwd_data10", ks_if.rk_data, R10);
        check("fwd_idx10",  128'(ks_if.rk_index), 128'd10);
      end
    end
    step();
    check("fwd_done",      128'(ks_if.done),      128'd1);
    check("fwd_key_ready", 128'(ks_if.key_ready), 128'd1);
    step();
    check("fwd_done_drop", 128'(ks_if.done), 128'd0);

    // Backpressure at index 5.
    start_key(K0, 1'b0);
    guard = 0;
    while (ks_if.rk_index != 4'd5 && guard < 20) begin step(); guard++; end
    ks_if.rk_ready = 1'b0;
    repeat (3) begin
      step();
      check("bp_idx",  128'(ks_if.rk_index), 128'd5);
      check("bp_data", ks_if.rk_data, all[640 +: 128]);
    end
    ks_if.rk_ready = 1'b1;
    wait_idle("bp_finish");

`ifdef KEY_SCHED_REVERSE_EN
    // Reverse stream: EXPAND for ten edges, then 10 down to 0.
    start_key(K0, 1'b1);
    repeat (9) step();
    check("rev_not_yet", 128'(ks_if.rk_valid), 128'd0);
    step();
    check("rev_first_valid", 128'(ks_if.rk_valid), 128'd1);
    check("rev_first_idx",   128'(ks_if.rk_index), 128'd10);
    check("rev_first_data",  ks_if.rk_data, R10);
    repeat (10) step();
    check("rev_last_idx",  128'(ks_if.rk_index), 128'd0);
    check("rev_last_data", ks_if.rk_data, K0);
    step();
    check("rev_done", 128'(ks_if.done), 128'd1);
    step();
`endif

    // Asynchronous reset while emitting index 4.
    start_key(K0, 1'b0);
    repeat (4) step();
    check("rst_mid_idx4", 128'(ks_if.rk_index), 128'd4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 128'(ks_if.rk_valid), 128'd0);
    check("rst_mid_idx",   128'(ks_if.rk_index), 128'd0);
    check("rst_mid_busy",  128'(ks_if.busy),     128'd0);
    step();
    rst_n = 1'b1;
    step();
    kb = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_key(kb, 1'b0);
    check("post_rst_idx",  128'(ks_if.rk_index), 128'd0);
    check("post_rst_data", ks_if.rk_data, kb);
    wait_idle("post_rst_finish");
    step();

    // key_valid held high while busy; second key taken in the done cycle.
    ks_if.key_in = K0; ks_if.dec = 1'b0; ks_if.key_valid = 1'b1; ks_if.rk_ready = 1'b1;
    step();
    kb = {$urandom(), $urandom(), $urandom(), $urandom()};
    ks_if.key_in = kb;
    repeat (5) step();
    check("b2b_blocked", 128'(ks_if.key_ready), 128'd0);
    repeat (5) step();
    check("b2b_idx10", 128'(ks_if.rk_data), R10);
    step();
    check("b2b_done",  128'(ks_if.done),      128'd1);
    check("b2b_ready", 128'(ks_if.key_ready), 128'd1);
    step();
    ks_if.key_valid = 1'b0;
    check("b2b_new_idx",  128'(ks_if.rk_index), 128'd0);
    check("b2b_new_data", ks_if.rk_data, kb);
    wait_idle("b2b_finish");

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      ks_if.key_valid = ($urandom_range(0, 3) == 0);
      ks_if.key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
      ks_if.dec       = $urandom_range(0, 1) == 1;
      ks_if.rk_ready  = ($urandom_range(0, 3) != 0);
      rst_n           = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    ks_if.key_valid = 1'b0;
    ks_if.rk_ready  = 1'b1;
    step();
    wait_idle("rand_drain");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
